mul_arbiter: RTL and testbench

- Shares one 64x64 radix-4 Booth multiplier datapath (`multiplier`, 32 compute cycles, level `op_done`) among NUM_REQ requesters.
- Arbitrates round-robin, holds the granted operands stable, and sequences the datapath's op_clear/op_start/op_done handshake.
- Returns the 128-bit product to the granted requester with a one-cycle ack.
- Sits between the requester units and the single multiplier instance.

---
 rtl/mul_arbiter_pkg.sv | 16 +
 rtl/mul_arbiter_if.sv | 26 ++
 rtl/mul_arbiter_rr_arbiter.sv | 30 +++
 rtl/mul_arbiter.sv | 115 +++++++++++
 tb/tb_mul_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_arbiter_pkg.sv
// Shared types and widths for the multiplier arbiter: FSM encoding,
// operand/product widths and the default datapath timeout.
package mul_arb_pkg;

    localparam int OPND_W          = 64;
    localparam int PROD_W          = 128;
    localparam int TMO_W           = 8;
    localparam int DEFAULT_TIMEOUT = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mul_arbiter_if.sv
// Link between the arbiter and the single shared Booth multiplier datapath.
interface mul_arbiter_if;
    import mul_arb_pkg::*;

    // Handshake: op_clear holds the datapath in INIT; op_start (never together
    // with op_clear) runs it; op_done is a level that stays high with a valid
    // result until op_clear returns. Requesters hold req until their one-cycle
    // ack pulse and drop it in the following cycle.
    logic [OPND_W-1:0] multiplier;
    logic [OPND_W-1:0] multiplicand;
    logic              op_start;
    logic              op_clear;
    logic              op_done;
    logic [PROD_W-1:0] result;

    modport master (
        output multiplier, multiplicand, op_start, op_clear,
        input  op_done, result
    );

    modport slave (
        input  multiplier, multiplicand, op_start, op_clear,
        output op_done, result
    );

endinterface

// File: rtl/mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   winner
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(pointer) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin front end sharing one 64x64 Booth multiplier among NUM_REQ
// requesters; sequences clear/start/done and returns the product with an ack.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*OPND_W-1:0] req_a,
    input  logic [NUM_REQ*OPND_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic [PROD_W-1:0]         rsp_result,
    output logic                      rsp_err,
    output logic                      busy,
    output arb_state_e                state,
    mul_arbiter_if.master             mul
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e         state_d;
    logic [PTR_W-1:0]   pointer;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tmo_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req     (req),
        .pointer (pointer),
        .grant   (win_onehot),
        .winner  (win_idx)
    );

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Clear is the default so the datapath restarts from cnt=0 for every operation.
    always_comb begin
        state_d      = state;
        busy         = 1'b0;
        ack          = '0;
        mul.op_clear = 1'b1;
        mul.op_start = 1'b0;
        case (state)
            IDLE: begin
                if (|req) state_d = RUN;
            end
            RUN: begin
                busy         = 1'b1;
                mul.op_clear = 1'b0;
                mul.op_start = 1'b1;
                if (mul.op_done || tmo_hit) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                ack     = gnt;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt              <= '0;
            pointer          <= '0;
            tmo_cnt          <= '0;
            rsp_result       <= '0;
            rsp_err          <= 1'b0;
            mul.multiplier   <= '0;
            mul.multiplicand <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        mul.multiplier   <= req_a[win_idx*OPND_W +: OPND_W];
                        mul.multiplicand <= req_b[win_idx*OPND_W +: OPND_W];
                        gnt              <= win_onehot;
                        pointer          <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                             : win_idx + PTR_W'(1);
                        tmo_cnt          <= '0;
                    end
                end
                RUN: begin
                    if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (mul.op_done) begin
                        rsp_result <= mul.result;
                        rsp_err    <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                    end
                end
                DONE: begin
                    gnt     <= '0;
                    tmo_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: stub 32-cycle datapath, directed requesters, and a
// monitor that pops expected grants/acks/products from a queue.
module tb_mul_arbiter;
    import mul_arb_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 40;
    localparam int EW  = 8 + N + 1 + 128;

    logic                clk;
    logic                reset;
    logic [N-1:0]        req;
    logic [N*64-1:0]     req_a;
    logic [N*64-1:0]     req_b;
    logic [N-1:0]        gnt;
    logic [N-1:0]        ack;
    logic [127:0]        rsp_result;
    logic                rsp_err;
    logic                busy;
    arb_state_e          dut_state;

    mul_arbiter_if mul_if ();

    mul_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .gnt        (gnt),
        .ack        (ack),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .state      (dut_state),
        .mul        (mul_if)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stub datapath ----------------
    logic [5:0] dp_cnt;
    logic       stub_dead = 1'b0;

    always @(posedge clk) begin
        if (mul_if.op_clear)                           dp_cnt <= '0;
        else if (mul_if.op_start && dp_cnt != 6'd32)   dp_cnt <= dp_cnt + 6'd1;
    end

    assign mul_if.op_done = (dp_cnt == 6'd32) && !stub_dead;
    assign mul_if.result  = $signed({{64{mul_if.multiplier[63]}}, mul_if.multiplier}) *
                            $signed({{64{mul_if.multiplicand[63]}}, mul_if.multiplicand});

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e;
    int            checks;
    int            errors;
    int            cyc;
    int            gnt_cyc;
    int            clr_start_viol;
    int            expired   = 0;
    int            acks_seen = 0;
    logic [N-1:0]  prev_gnt;
    logic [N-1:0]  persist   = '0;
    logic [N-1:0]  drop      = '0;
    logic          chk_reset = 1'b0;
    logic          chk_idle  = 1'b0;
    logic          tb_done   = 1'b0;

    function automatic logic [EW-1:0] mk(input int lat, input logic [N-1:0] g,
                                         input logic err, input logic [127:0] res);
        return {8'(lat), g, err, res};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        checks = 0; errors = 0; cyc = 0; gnt_cyc = 0; clr_start_viol = 0; prev_gnt = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mul_if.op_clear === 1'b1 && mul_if.op_start === 1'b1) clr_start_viol++;
            if (chk_reset) begin
                check("rst_state",        128'(dut_state),               128'(IDLE));
                check("rst_gnt",          128'(gnt),                     128'(0));
                check("rst_ack",          128'(ack),                     128'(0));
                check("rst_rsp_result",   rsp_result,                    128'(0));
                check("rst_rsp_err",      128'(rsp_err),                 128'(0));
                check("rst_busy",         128'(busy),                    128'(0));
                check("rst_multiplier",   128'(mul_if.multiplier),       128'(0));
                check("rst_multiplicand", 128'(mul_if.multiplicand),     128'(0));
                check("rst_op_start",     128'(mul_if.op_start),         128'(0));
                check("rst_op_clear",     128'(mul_if.op_clear),         128'(1));
            end
            if (chk_idle) begin
                check("idle_busy",     128'(busy),            128'(0));
                check("idle_gnt",      128'(gnt),             128'(0));
                check("idle_state",    128'(dut_state),       128'(IDLE));
                check("idle_op_clear", 128'(mul_if.op_clear), 128'(1));
                check("idle_op_start", 128'(mul_if.op_start), 128'(0));
            end
            if (gnt != '0 && prev_gnt == '0) begin
                gnt_cyc = cyc;
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    check("grant_order", 128'(gnt), 128'(e[132:129]));
                end
            end
            if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 128'(ack), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("ack_onehot", 128'(ack),             128'(e[132:129]));
                    check("rsp_err",    128'(rsp_err),         128'(e[128]));
                    check("rsp_result", rsp_result,            e[127:0]);
                    check("latency",    128'(cyc - gnt_cyc),   128'(e[140:133]));
                end
            end
            prev_gnt = gnt;
            if (tb_done) begin
                check("clear_start_exclusive", 128'(clr_start_viol), 128'(0));
                check("wait_budget",           128'(expired),        128'(0));
                check("queue_drained",         128'(exp_q.size()),   128'(0));
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        acks_seen += $countones(ack);
        drop = ack & ~persist;
        @(posedge clk);
        #1;
        req = req & ~drop;
    endtask

    task automatic wait_acks(input int k);
        int goal = acks_seen + k;
        int n    = 0;
        while (acks_seen < goal && n < 60 * k) begin
            step();
            n++;
        end
        if (acks_seen < goal) expired++;
    endtask

    task automatic wait_gnt();
        int n = 0;
        while (gnt == '0 && n < 10) begin
            step();
            n++;
        end
        if (gnt == '0) expired++;
    endtask

    task automatic idle_check();
        chk_idle = 1'b1;
        @(negedge clk);
        #1 chk_idle = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_opnd(input int i, input logic [63:0] a, input logic [63:0] b);
        req_a[i*64 +: 64] = a;
        req_b[i*64 +: 64] = b;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; req = '0; req_a = '0; req_b = '0;
        #1 reset = 1'b1;
        chk_reset = 1'b1;
        @(negedge clk);
        #1 chk_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // single request: 3*5
        set_opnd(0, 64'd3, 64'd5);
        exp_q.push_back(mk(33, 4'b0001, 1'b0, 128'd15));
        req[0] = 1'b1;
        wait_acks(1);
        idle_check();

        // full-width signed: -1 * (2^63-1)
        set_opnd(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
        exp_q.push_back(mk(33, 4'b1000, 1'b0, 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001));
        req[3] = 1'b1;
        wait_acks(1);

        // all four at once: served 0,1,2,3
        set_opnd(0, 64'd2, 64'd3);
        set_opnd(1, 64'd100, 64'd200);
        set_opnd(2, 64'hFFFF_FFFF_FFFF_FFFB, 64'd7);
        set_opnd(3, 64'h1_0000_0000, 64'h1_0000_0000);
        exp_q.push_back(mk(33, 4'b0001, 1'b0, 128'd6));
        exp_q.push_back(mk(33, 4'b0010, 1'b0, 128'd20000));
        exp_q.push_back(mk(33, 4'b0100, 1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFDD));
        exp_q.push_back(mk(33, 4'b1000, 1'b0, 128'h1_0000_0000_0000_0000));
        req = 4'b1111;
        wait_acks(4);
        idle_check();

        // re-request fairness: 0 and 2 keep requesting -> 0,2,0,2
        set_opnd(0, 64'd11, 64'd13);
        set_opnd(2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD);
        exp_q.push_back(mk(33, 4'b0001, 1'b0, 128'd143));
        exp_q.push_back(mk(33, 4'b0100, 1'b0, 128'd6));
        exp_q.push_back(mk(33, 4'b0001, 1'b0, 128'd143));
        exp_q.push_back(mk(33, 4'b0100, 1'b0, 128'd6));
        persist = 4'b0101;
        req     = 4'b0101;
        wait_acks(2);
        persist = '0;
        wait_acks(2);
        idle_check();

        // datapath never finishes -> timeout error
        stub_dead = 1'b1;
        set_opnd(1, 64'd7, 64'd9);
        exp_q.push_back(mk(TMO, 4'b0010, 1'b1, 128'd0));
        req[1] = 1'b1;
        wait_acks(1);
        stub_dead = 1'b0;
        idle_check();

        // next request after a timeout is served normally
        set_opnd(1, 64'd6, 64'd7);
        exp_q.push_back(mk(33, 4'b0010, 1'b0, 128'd42));
        req[1] = 1'b1;
        wait_acks(1);

        // reset in the middle of RUN: no ack, immediate return to reset values
        set_opnd(2, 64'd10, 64'd11);
        req[2] = 1'b1;
        wait_gnt();
        repeat (9) step();
        reset     = 1'b1;
        chk_reset = 1'b1;
        @(negedge clk);
        #1 chk_reset = 1'b0;
        req = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // request after reset release
        exp_q.push_back(mk(33, 4'b0100, 1'b0, 128'd110));
        req[2] = 1'b1;
        wait_acks(1);
        idle_check();

        tb_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
